cpu_prefetch: RTL and testbench

CPU_PREFETCH -- requirements
Module: cpu_prefetch

---
 rtl/cpu_prefetch_pkg.sv | 23 ++
 rtl/cpu_prefetch_fifo.sv | 59 +++++
 rtl/cpu_prefetch.sv | 125 ++++++++++++
 tb/tb_cpu_prefetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_prefetch_pkg.sv
// Shared CPU definitions used by the instruction prefetch unit and its queue.
package cpu_prefetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StFlush = 2'd2
    } pf_state_e;

    // One queue entry: fetched word, its byte address and the skip-upper-half flag.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        skip;
    } pf_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_prefetch_fifo.sv
// Instruction word queue: DEPTH entries of data, address and skip, with flush.
module cpu_prefetch_fifo
    import cpu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  pf_entry_t                push_entry_i,
    input  logic                     pop_i,
    output pf_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    pf_entry_t       mem_q [DEPTH];
    logic            do_push, do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // Issue is gated by free space, so a push into a full queue is a design bug.
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(do_push && full_o));
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cpu_prefetch.sv
// Wishbone instruction prefetcher: fetches sequential words into a queue, redirects on branch.
module cpu_prefetch
    import cpu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_I_adr_o,
    input  logic [31:0] wb_I_dat_i,
    input  logic        wb_I_ack_i,
    output logic        wb_I_stb_o,
    output logic        wb_I_cyc_o,
    output logic        wb_I_we_o,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] word_o,
    output logic [31:0] word_addr_o,
    output logic        word_skip_o,
    output logic        word_valid_o,
    input  logic        word_ready_i
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    pf_state_e       state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     adr_q, adr_d;
    logic            pend_skip_q, pend_skip_d;
    logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    pf_entry_t       push_entry, head;
    logic [CntW-1:0] count, count_after_pop;
    logic            ack;
    logic            unused_tgt_bit0;

    assign unused_tgt_bit0 = branch_target_i[0];

    assign ack             = wb_I_ack_i & (state_q != StIdle);
    assign fifo_pop        = ~fifo_empty & word_ready_i & ~branch_flag_i;
    assign count_after_pop = count - CntW'(fifo_pop);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        adr_d       = adr_q;
        pend_skip_d = pend_skip_q;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        push_entry  = '{data: wb_I_dat_i, addr: fetch_pc_q, skip: pend_skip_q};
        unique case (state_q)
            StIdle: begin
                if (branch_flag_i) begin
                    fifo_flush  = 1'b1;
                    fetch_pc_d  = align_word(branch_target_i);
                    pend_skip_d = branch_target_i[1];
                end else if (!fifo_full || fifo_pop) begin
                    state_d = StReq;
                    adr_d   = fetch_pc_q;
                end
            end
            StReq: begin
                if (branch_flag_i) begin
                    fifo_flush  = 1'b1;
                    fetch_pc_d  = align_word(branch_target_i);
                    pend_skip_d = branch_target_i[1];
                    state_d     = ack ? StIdle : StFlush;
                end else if (ack) begin
                    fifo_push   = 1'b1;
                    fetch_pc_d  = fetch_pc_q + 32'd4;
                    adr_d       = fetch_pc_q + 32'd4;
                    pend_skip_d = 1'b0;
                    state_d     = (count_after_pop < CntW'(DEPTH - 1)) ? StReq : StIdle;
                end
            end
            StFlush: begin
                // The bus cycle for the stale address must complete before refetching.
                if (branch_flag_i) begin
                    fetch_pc_d  = align_word(branch_target_i);
                    pend_skip_d = branch_target_i[1];
                end
                if (ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            adr_q       <= RESET_PC;
            pend_skip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            adr_q       <= adr_d;
            pend_skip_q <= pend_skip_d;
        end
    end

    cpu_prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_entry_i(push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign wb_I_adr_o   = adr_q;
    assign wb_I_stb_o   = (state_q != StIdle);
    assign wb_I_cyc_o   = (state_q != StIdle);
    assign wb_I_we_o    = 1'b0;
    assign word_o       = head.data;
    assign word_addr_o  = head.addr;
    assign word_skip_o  = head.skip & ~fifo_empty;
    assign word_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_cpu_prefetch.sv
// Self-checking bench for cpu_prefetch: directed scenarios plus a randomized stream check.
module tb_cpu_prefetch;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr, wb_dat;
    logic        wb_ack, wb_stb, wb_cyc, wb_we;
    logic        br_flag;
    logic [31:0] br_target;
    logic [31:0] word, word_addr;
    logic        word_skip, word_valid, word_ready;
    logic        ack_auto, ack_man;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    assign wb_ack = ack_auto ? wb_stb : ack_man;
    assign wb_dat = mem_word(wb_adr);

    cpu_prefetch #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_1000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wb_I_adr_o     (wb_adr),
        .wb_I_dat_i     (wb_dat),
        .wb_I_ack_i     (wb_ack),
        .wb_I_stb_o     (wb_stb),
        .wb_I_cyc_o     (wb_cyc),
        .wb_I_we_o      (wb_we),
        .branch_flag_i  (br_flag),
        .branch_target_i(br_target),
        .word_o         (word),
        .word_addr_o    (word_addr),
        .word_skip_o    (word_skip),
        .word_valid_o   (word_valid),
        .word_ready_i   (word_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        br_flag    = 1'b0;
        br_target  = '0;
        word_ready = 1'b0;
        ack_auto   = 1'b0;
        ack_man    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        br_flag    = 1'b0;
        br_target  = '0;
        word_ready = 1'b1;
        ack_auto   = 1'b1;
        ack_man    = 1'b0;
        tick();
        tick();
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", wb_stb); end
        checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b exp 0", wb_cyc); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", wb_we); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid); end
        checks++; if (word_skip !== 1'b0) begin errors++; $display("FAIL reset_skip got %b exp 0", word_skip); end
        checks++; if (wb_adr !== 32'h1000) begin errors++; $display("FAIL reset_adr got %h exp 00001000", wb_adr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_a;
        do_reset();
        ack_auto   = 1'b1;
        word_ready = 1'b1;
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL stream_first_cycle_stb got %b exp 0", wb_stb); end
        tick();
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h1000) begin
            errors++; $display("FAIL stream_first_req got stb=%b adr=%h exp stb=1 adr=00001000", wb_stb, wb_adr);
        end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass got %b exp 0", word_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_a = 32'h1000 + 32'(4 * i);
            checks++; if (word_valid !== 1'b1 || word_addr !== exp_a) begin
                errors++; $display("FAIL stream_addr%0d got v=%b a=%h exp v=1 a=%h", i, word_valid, word_addr, exp_a);
            end
            checks++; if (word !== mem_word(exp_a) || word_skip !== 1'b0) begin
                errors++; $display("FAIL stream_data%0d got %h/%b exp %h/0", i, word, word_skip, mem_word(exp_a));
            end
        end
    endtask

    task automatic test_backpressure();
        int          n_acks;
        logic [31:0] ack_adr;
        do_reset();
        ack_auto = 1'b1;
        n_acks   = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (wb_stb && wb_ack) n_acks++;
        end
        checks++; if (n_acks != DEPTH) begin errors++; $display("FAIL bp_fill_acks got %0d exp %0d", n_acks, DEPTH); end
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL bp_stb_idle got %b exp 0", wb_stb); end
        checks++; if (word_valid !== 1'b1 || word_addr !== 32'h1000) begin
            errors++; $display("FAIL bp_head got v=%b a=%h exp v=1 a=00001000", word_valid, word_addr);
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        checks++; if (word_addr !== 32'h1004) begin errors++; $display("FAIL bp_pop_head got %h exp 00001004", word_addr); end
        n_acks  = 0;
        ack_adr = '0;
        for (int i = 0; i < 12; i++) begin
            if (wb_stb && wb_ack) begin
                n_acks++;
                ack_adr = wb_adr;
            end
            tick();
        end
        checks++; if (n_acks != 1 || ack_adr !== 32'h1010) begin
            errors++; $display("FAIL bp_refill got n=%0d adr=%h exp n=1 adr=00001010", n_acks, ack_adr);
        end
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL bp_stb_after_refill got %b exp 0", wb_stb); end
    endtask

    task automatic test_branch_delayed();
        do_reset();
        tick();
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        checks++; if (word_valid !== 1'b1 || wb_stb !== 1'b1 || wb_adr !== 32'h1004) begin
            errors++; $display("FAIL brd_setup got v=%b stb=%b adr=%h exp v=1 stb=1 adr=00001004",
                               word_valid, wb_stb, wb_adr);
        end
        br_flag   = 1'b1;
        br_target = 32'h2002;
        tick();
        br_flag = 1'b0;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL brd_queue_cleared got %b exp 0", word_valid); end
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h1004) begin
            errors++; $display("FAIL brd_stb_held got stb=%b adr=%h exp stb=1 adr=00001004", wb_stb, wb_adr);
        end
        tick();
        tick();
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        checks++; if (word_valid !== 1'b0 || wb_stb !== 1'b0) begin
            errors++; $display("FAIL brd_drop got v=%b stb=%b exp v=0 stb=0", word_valid, wb_stb);
        end
        tick();
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h2000) begin
            errors++; $display("FAIL brd_refetch got stb=%b adr=%h exp stb=1 adr=00002000", wb_stb, wb_adr);
        end
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        checks++; if (word_valid !== 1'b1 || word_addr !== 32'h2000 || word_skip !== 1'b1) begin
            errors++; $display("FAIL brd_head got v=%b a=%h s=%b exp v=1 a=00002000 s=1",
                               word_valid, word_addr, word_skip);
        end
        checks++; if (word !== mem_word(32'h2000)) begin
            errors++; $display("FAIL brd_data got %h exp %h", word, mem_word(32'h2000));
        end
    endtask

    task automatic test_branch_with_ack();
        do_reset();
        tick();
        ack_man   = 1'b1;
        br_flag   = 1'b1;
        br_target = 32'h3000;
        tick();
        ack_man = 1'b0;
        br_flag = 1'b0;
        checks++; if (word_valid !== 1'b0 || wb_stb !== 1'b0) begin
            errors++; $display("FAIL bra_drop got v=%b stb=%b exp v=0 stb=0", word_valid, wb_stb);
        end
        tick();
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h3000) begin
            errors++; $display("FAIL bra_refetch got stb=%b adr=%h exp stb=1 adr=00003000", wb_stb, wb_adr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        tick();
        rst     = 1'b1;
        ack_man = 1'b1;
        tick();
        rst     = 1'b0;
        ack_man = 1'b0;
        checks++; if (wb_stb !== 1'b0 || word_valid !== 1'b0 || wb_adr !== 32'h1000) begin
            errors++; $display("FAIL rstm_abort got stb=%b v=%b adr=%h exp stb=0 v=0 adr=00001000",
                               wb_stb, word_valid, wb_adr);
        end
        tick();
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h1000 || word_valid !== 1'b0) begin
            errors++; $display("FAIL rstm_restart got stb=%b adr=%h v=%b exp stb=1 adr=00001000 v=0",
                               wb_stb, wb_adr, word_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ack_auto   = 1'b1;
        word_ready = 1'b1;
        br_flag    = 1'b1;
        br_target  = 32'hFFFF_FFFC;
        tick();
        br_flag = 1'b0;
        tick();
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first got stb=%b adr=%h exp stb=1 adr=fffffffc", wb_stb, wb_adr);
        end
        tick();
        checks++; if (wb_adr !== 32'h0 || word_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_next got adr=%h head=%h exp adr=00000000 head=fffffffc", wb_adr, word_addr);
        end
        tick();
        checks++; if (word_valid !== 1'b1 || word_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_head got v=%b a=%h exp v=1 a=00000000", word_valid, word_addr);
        end
    endtask

    // Expected stream: consecutive words from the last redirect target, first one carrying its skip.
    task automatic test_random();
        logic [31:0] exp_addr, prev_adr, tgt;
        logic        exp_skip, prev_hold, br;
        int          pops;
        do_reset();
        exp_addr  = 32'h1000;
        exp_skip  = 1'b0;
        prev_hold = 1'b0;
        prev_adr  = '0;
        pops      = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (wb_cyc !== wb_stb || wb_we !== 1'b0) begin
                errors++; $display("FAIL rnd_bus_ctrl c%0d got cyc=%b stb=%b we=%b", cyc, wb_cyc, wb_stb, wb_we);
            end
            if (prev_hold) begin
                checks++; if (wb_stb !== 1'b1 || wb_adr !== prev_adr) begin
                    errors++; $display("FAIL rnd_hold c%0d got stb=%b adr=%h exp stb=1 adr=%h",
                                       cyc, wb_stb, wb_adr, prev_adr);
                end
            end
            ack_man    = wb_stb && ($urandom_range(2) != 0);
            word_ready = ($urandom_range(3) != 0);
            br         = ($urandom_range(39) == 0);
            tgt        = $urandom;
            tgt[0]     = 1'b0;
            br_flag    = br;
            br_target  = tgt;
            if (word_valid && word_ready && !br) begin
                checks++; if (word_addr !== exp_addr || word !== mem_word(exp_addr) || word_skip !== exp_skip) begin
                    errors++; $display("FAIL rnd_pop c%0d got a=%h d=%h s=%b exp a=%h d=%h s=%b", cyc,
                                       word_addr, word, word_skip, exp_addr, mem_word(exp_addr), exp_skip);
                end
                exp_addr = exp_addr + 32'd4;
                exp_skip = 1'b0;
                pops++;
            end
            if (br) begin
                exp_addr = {tgt[31:2], 2'b00};
                exp_skip = tgt[1];
            end
            prev_hold = wb_stb && !ack_man;
            prev_adr  = wb_adr;
            tick();
        end
        br_flag = 1'b0;
        checks++; if (pops < 300) begin errors++; $display("FAIL rnd_progress got %0d pops exp >= 300", pops); end
    endtask

    initial begin
        rst        = 1'b1;
        br_flag    = 1'b0;
        br_target  = '0;
        word_ready = 1'b0;
        ack_auto   = 1'b0;
        ack_man    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_delayed();
        test_branch_with_ack();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
